// File: rtl/t02_ram_responder.sv
// Single-port RAM responder: accepts one read/write at a time, stays busy for
// LATENCY cycles, then commits the write or returns read data with an ack pulse.
module t02_ram_responder #(
  parameter int    ADDR_W    = 10,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        Ren,
  input  logic        Wen,
  output logic [31:0] ramload,
  output logic        busy_o,
  output logic        ack_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  logic [31:0]       mem [0:(2**ADDR_W)-1];
  state_t            state_r;
  state_t            state_s;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] idx_r;
  logic [31:0]       data_r;
  logic              wr_r;
  logic              oor_r;
  logic              busy_r;
  logic              ack_r;
  logic              err_r;
  logic [31:0]       ramload_r;
  logic              accept_s;
  logic              complete_s;
  logic              oor_in_s;

  assign oor_in_s = |ramaddr[31:ADDR_W+2];

  // Next-state decode; accept only in IDLE, complete when the wait counter hits zero.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (Ren || Wen) begin
          accept_s = 1'b1;
          state_s  = BUSY;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          complete_s = 1'b1;
          state_s    = DONE;
        end else begin
          state_s    = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= {ADDR_W{1'b0}};
      data_r    <= 32'd0;
      wr_r      <= 1'b0;
      oor_r     <= 1'b0;
      busy_r    <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      ramload_r <= 32'd0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == BUSY);
      ack_r   <= (state_s == DONE);
      err_r   <= (state_s == DONE) && oor_r;
      if (accept_s) begin
        // Write takes priority when both requests are raised together.
        idx_r  <= ramaddr[ADDR_W+1:2];
        data_r <= ramstore;
        wr_r   <= Wen;
        oor_r  <= oor_in_s;
        cnt_r  <= LAT_LOAD;
      end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (complete_s && !wr_r) begin
        ramload_r <= oor_r ? 32'd0 : mem[idx_r];
      end
    end
  end

  // Memory array write port; not reset, and a reset edge suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (nrst && complete_s && wr_r && !oor_r) begin
      mem[idx_r] <= data_r;
    end
  end

  assign ramload = ramload_r;
  assign busy_o  = busy_r;
  assign ack_o   = ack_r;
  assign err_o   = err_r;

endmodule

// File: tb/tb_t02_ram_responder.sv
// Scoreboard bench for t02_ram_responder: expectations are queued when a request
// is driven and compared against each ack_o pulse.
module tb_t02_ram_responder;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;

  logic        clk;
  logic        nrst;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramload;
  logic        busy_o;
  logic        ack_o;
  logic        err_o;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        rd;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          n_checks;
  int          n_pass;
  int          ack_count;
  int          busy_run;

  t02_ram_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .INIT_FILE("")) dut (
    .clk(clk), .nrst(nrst), .ramaddr(ramaddr), .ramstore(ramstore),
    .Ren(Ren), .Wen(Wen), .ramload(ramload), .busy_o(busy_o),
    .ack_o(ack_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic is_oor(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) != 32'd0;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << ADDR_W) - 32'd1));
  endfunction

  // Scoreboard monitor: pops one expectation per ack_o pulse, measures busy length.
  always @(negedge clk) begin
    exp_t e;
    if (!nrst) begin
      busy_run = 0;
    end else if (ack_o) begin
      ack_count++;
      if (sb.size() == 0) begin
        check("spurious_ack", 32'(ack_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_err"}, 32'(err_o), 32'(e.err));
        if (e.rd) check({e.tag, "_data"}, ramload, e.data);
        check({e.tag, "_busy_len"}, 32'(busy_run), 32'(LATENCY));
      end
      busy_run = 0;
    end else begin
      if (err_o) check("err_without_ack", 32'(err_o), 32'd0);
      if (busy_o) busy_run++;
    end
  end

  task automatic push_exp(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input string tag, input logic chk_data);
    exp_t e;
    e.tag  = tag;
    e.err  = is_oor(a);
    e.rd   = chk_data && r && !w;
    e.data = 32'd0;
    if (!w && !is_oor(a) && model.exists(idx_of(a))) e.data = model[idx_of(a)];
    if (w && !is_oor(a)) model[idx_of(a)] = d;
    sb.push_back(e);
  endtask

  task automatic wait_acks(input int target, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (ack_count >= target) break;
      @(negedge clk);
      #1;
    end
    if (ack_count < target) check({tag, "_timeout"}, 32'(ack_count), 32'(target));
  endtask

  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int start;
    @(negedge clk);
    Ren = r; Wen = w; ramaddr = a; ramstore = d;
    push_exp(r, w, a, d, tag, 1'b1);
    start = ack_count;
    @(posedge clk);
    #1;
    Ren = 1'b0; Wen = 1'b0;
    wait_acks(start + 1, tag);
  endtask

  initial begin
    int start;
    n_checks = 0; n_pass = 0; ack_count = 0; busy_run = 0;
    nrst = 1'b0; Ren = 1'b1; Wen = 1'b0; ramaddr = 32'd0; ramstore = 32'd0;

    // Reset held with Ren high, then released: accepted on the first live edge.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_ramload", ramload, 32'd0);
    nrst = 1'b1;
    push_exp(1'b1, 1'b0, 32'd0, 32'd0, "rst_release", 1'b0);
    start = ack_count;
    @(posedge clk);
    #1;
    Ren = 1'b0;
    @(negedge clk);
    check("accept_after_reset", 32'(busy_o), 32'd1);
    wait_acks(start + 1, "rst_release");

    // Basic write then read with a non-zero byte offset.
    do_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
    do_req(1'b1, 1'b0, 32'h0000_0013, 32'h0, "rd13");

    // Simultaneous Ren+Wen is a write.
    do_req(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, "rw20");
    do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, "rd20");

    // Out-of-range accesses alias onto index 0 if the range check is broken.
    do_req(1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_0001, "wr0");
    do_req(1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, "wr_oor");
    do_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, "rd_oor");
    do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, "rd0");
    do_req(1'b1, 1'b0, 32'h8000_0010, 32'h0, "rd_oor_hi");

    // Wen held through BUSY and DONE while address/data change.
    @(negedge clk);
    Wen = 1'b1; ramaddr = 32'h0000_0080; ramstore = 32'h1111_1111;
    push_exp(1'b0, 1'b1, 32'h0000_0080, 32'h1111_1111, "hold1", 1'b1);
    push_exp(1'b0, 1'b1, 32'h0000_0084, 32'h2222_2222, "hold2", 1'b1);
    start = ack_count;
    @(posedge clk);
    for (int i = 1; i <= LATENCY + 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        ramaddr = 32'h0000_0084; ramstore = 32'h2222_2222;
      end
      if (i == LATENCY + 2) check("no_accept_in_done", 32'(busy_o), 32'd0);
      if (i == LATENCY + 3) begin
        check("accept_after_done", 32'(busy_o), 32'd1);
        Wen = 1'b0;
      end
    end
    wait_acks(start + 2, "hold");
    do_req(1'b1, 1'b0, 32'h0000_0080, 32'h0, "rd80");
    do_req(1'b1, 1'b0, 32'h0000_0084, 32'h0, "rd84");

    // Reset during the second busy cycle aborts a pending write.
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, "wr40");
    @(negedge clk);
    Wen = 1'b1; ramaddr = 32'h0000_0040; ramstore = 32'hAAAA_5555;
    start = ack_count;
    @(posedge clk);
    #1;
    Wen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before_rst", 32'(busy_o), 32'd1);
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_ramload", ramload, 32'd0);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_ack", 32'(ack_count), 32'(start));
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, "rd40");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
